// File: rtl/mod_toggle_counter_pkg.sv
// Shared mode encoding for the toggle-cell counter family.
package mod_toggle_counter_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_t;

endpackage : mod_toggle_counter_pkg

// File: rtl/mod_toggle_counter_tff_cell.sv
// Single T flop with per-bit reset value and a synchronous load that beats toggle.
module tff_cell
  import mod_toggle_counter_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic d_load_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next bit: load wins, otherwise toggle when t is set.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_load_i;
    end else if (t_i) begin
      q_d = ~q_q;
    end
  end

  // Bit storage with asynchronous reset to its own reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : tff_cell

// File: rtl/mod_toggle_counter.sv
// Modulo up/down counter or raw toggle bank built from WIDTH toggle cells,
// with parallel load, terminal count, wrap pulse and sticky wrap flag.
module mod_toggle_counter
  import mod_toggle_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MODULUS     = 2 ** WIDTH,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] t_vec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_sticky_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             wrap_sticky_o
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_next_c;
  logic [WIDTH-1:0] toggle_c;
  logic [WIDTH-1:0] load_clamp_c;
  logic             up_end_c;
  logic             dn_end_c;
  logic             is_up_c;
  logic             is_dn_c;
  logic             wrap_event_c;
  logic             wrap_q;
  logic             wrap_d;
  logic             sticky_q;
  logic             sticky_d;

  // Mode decode and end-of-range detection; out-of-range q counts as the top end.
  always_comb begin
    is_up_c  = (mode_i == MODE_UP);
    is_dn_c  = (mode_i == MODE_DOWN);
    up_end_c = (cnt_q >= MAX_Q);
    dn_end_c = (cnt_q == '0);
  end

  // Counter value the arithmetic modes would produce on an enabled edge.
  always_comb begin
    cnt_next_c = cnt_q;
    case (mode_i)
      MODE_UP:     cnt_next_c = up_end_c ? '0 : cnt_q + WIDTH'(1);
      MODE_DOWN:   cnt_next_c = dn_end_c ? MAX_Q : cnt_q - WIDTH'(1);
      MODE_TOGGLE: cnt_next_c = cnt_q ^ t_vec_i;
      default:     cnt_next_c = cnt_q;
    endcase
  end

  // Per-bit toggle enables: raw t_vec in TOGGLE, otherwise the bits that change.
  always_comb begin
    toggle_c = '0;
    if (en_i) begin
      if (mode_i == MODE_TOGGLE) begin
        toggle_c = t_vec_i;
      end else begin
        toggle_c = cnt_next_c ^ cnt_q;
      end
    end
  end

  // Load value clamped into the counting range.
  always_comb begin
    load_clamp_c = load_val_i;
    if (load_val_i > MAX_Q) begin
      load_clamp_c = MAX_Q;
    end
  end

  // Terminal count and the wrap event actually taken on this edge.
  always_comb begin
    tc_o         = en_i & ~load_i & ((is_up_c & up_end_c) | (is_dn_c & dn_end_c));
    wrap_event_c = tc_o;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell #(
        .RESET_BIT (RST_Q[gi])
      ) u_cell (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_i),
        .d_load_i (load_clamp_c[gi]),
        .t_i      (toggle_c[gi]),
        .q_o      (cnt_q[gi])
      );
    end
  endgenerate

  // Wrap pulse and sticky flag next state; a set beats a coincident clear.
  always_comb begin
    wrap_d   = wrap_event_c;
    sticky_d = (sticky_q & ~clr_sticky_i) | wrap_event_c;
  end

  // Wrap status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign q_o           = cnt_q;
  assign wrap_o        = wrap_q;
  assign wrap_sticky_o = sticky_q;

endmodule : mod_toggle_counter

// File: tb/tb_mod_toggle_counter.sv
// Directed bench for mod_toggle_counter: WIDTH=4/MODULUS=10 main instance plus
// a WIDTH=2/MODULUS=2/RESET_VALUE=1 edge instance.
module tb_mod_toggle_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_vec;
  logic       load;
  logic [3:0] load_val;
  logic       clr_sticky;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       wrap_sticky;

  logic       reset2;
  logic       en2;
  logic [1:0] mode2;
  logic [1:0] q2;
  logic       tc2;
  logic       wrap2;
  logic       wrap_sticky2;

  int n_tests;
  int n_fail;

  mod_toggle_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .mode_i        (mode),
    .t_vec_i       (t_vec),
    .load_i        (load),
    .load_val_i    (load_val),
    .clr_sticky_i  (clr_sticky),
    .q_o           (q),
    .tc_o          (tc),
    .wrap_o        (wrap),
    .wrap_sticky_o (wrap_sticky)
  );

  mod_toggle_counter #(.WIDTH(2), .MODULUS(2), .RESET_VALUE(1)) u_dut2 (
    .clk           (clk),
    .reset         (reset2),
    .en_i          (en2),
    .mode_i        (mode2),
    .t_vec_i       (2'b00),
    .load_i        (1'b0),
    .load_val_i    (2'b00),
    .clr_sticky_i  (1'b0),
    .q_o           (q2),
    .tc_o          (tc2),
    .wrap_o        (wrap2),
    .wrap_sticky_o (wrap_sticky2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    reset2     = 1'b1;
    en         = 1'b0;
    mode       = 2'b00;
    t_vec      = 4'h0;
    load       = 1'b0;
    load_val   = 4'h0;
    clr_sticky = 1'b0;
    en2        = 1'b0;
    mode2      = 2'b00;

    // Reset state
    #12;
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_wrap", 32'(wrap), 32'h0);
    check_eq("rst_sticky", 32'(wrap_sticky), 32'h0);
    check_eq("rst_q2", 32'(q2), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // UP count through a wrap
    en   = 1'b1;
    mode = 2'b01;
    #1;
    check_eq("up_tc0", 32'(tc), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("up_q", 32'(q), 32'(k % 10));
      check_eq("up_wrap", 32'(wrap), 32'(k == 10));
      check_eq("up_tc", 32'(tc), 32'((k % 10) == 9));
      check_eq("up_sticky", 32'(wrap_sticky), 32'(k >= 10));
    end

    // DOWN wrap after loading 2
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'h2;
    step();
    check_eq("ld2_q", 32'(q), 32'h2);
    load = 1'b0;
    en   = 1'b1;
    mode = 2'b10;
    step(); check_eq("dn_q1", 32'(q), 32'h1);
    step(); check_eq("dn_q0", 32'(q), 32'h0);
    check_eq("dn_tc0", 32'(tc), 32'h1);
    step(); check_eq("dn_q9", 32'(q), 32'h9);
    check_eq("dn_wrap9", 32'(wrap), 32'h1);
    step(); check_eq("dn_q8", 32'(q), 32'h8);
    check_eq("dn_wrap8", 32'(wrap), 32'h0);

    // Sticky clear in a quiet cycle
    en         = 1'b0;
    clr_sticky = 1'b1;
    step();
    check_eq("clr_sticky", 32'(wrap_sticky), 32'h0);
    check_eq("clr_q_hold", 32'(q), 32'h8);
    clr_sticky = 1'b0;
    en         = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      step();
      check_eq("dn_run", 32'(q), 32'(k));
    end

    // Clear coinciding with a wrap: set wins
    clr_sticky = 1'b1;
    step();
    check_eq("coin_q", 32'(q), 32'h9);
    check_eq("coin_wrap", 32'(wrap), 32'h1);
    check_eq("coin_sticky", 32'(wrap_sticky), 32'h1);
    step();
    check_eq("coin_after", 32'(wrap_sticky), 32'h0);
    clr_sticky = 1'b0;

    // Load priority with clamp
    load     = 1'b1;
    load_val = 4'hC;
    mode     = 2'b01;
    en       = 1'b1;
    step();
    check_eq("clamp_q", 32'(q), 32'h9);
    check_eq("clamp_wrap", 32'(wrap), 32'h0);
    check_eq("clamp_tc", 32'(tc), 32'h0);
    load_val = 4'h3;
    en       = 1'b0;
    step();
    check_eq("ld3_q", 32'(q), 32'h3);

    // TOGGLE mode, then UP from an out-of-range value
    load_val = 4'h0;
    step();
    check_eq("ld0_q", 32'(q), 32'h0);
    load  = 1'b0;
    en    = 1'b1;
    mode  = 2'b11;
    t_vec = 4'b1010;
    step();
    check_eq("tog_qA", 32'(q), 32'hA);
    check_eq("tog_wrap", 32'(wrap), 32'h0);
    check_eq("tog_tc", 32'(tc), 32'h0);
    step();
    check_eq("tog_q0", 32'(q), 32'h0);
    check_eq("tog_wrap2", 32'(wrap), 32'h0);
    step();
    check_eq("tog_qA2", 32'(q), 32'hA);
    mode = 2'b01;
    #1;
    check_eq("oor_tc", 32'(tc), 32'h1);
    step();
    check_eq("oor_q", 32'(q), 32'h0);
    check_eq("oor_wrap", 32'(wrap), 32'h1);
    check_eq("oor_sticky", 32'(wrap_sticky), 32'h1);

    // Async reset mid-count at q=7
    load     = 1'b1;
    load_val = 4'h7;
    step();
    load = 1'b0;
    check_eq("pre_rst_q", 32'(q), 32'h7);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_q", 32'(q), 32'h0);
    check_eq("arst_wrap", 32'(wrap), 32'h0);
    check_eq("arst_sticky", 32'(wrap_sticky), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(); check_eq("resume_q1", 32'(q), 32'h1);
    step(); check_eq("resume_q2", 32'(q), 32'h2);

    // MODULUS=2, RESET_VALUE=1 instance
    en = 1'b0;
    @(negedge clk);
    reset2 = 1'b0;
    en2    = 1'b1;
    mode2  = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("m2_q", 32'(q2), 32'(k % 2 == 0));
      check_eq("m2_wrap", 32'(wrap2), 32'(k % 2 == 1));
    end
    check_eq("m2_sticky", 32'(wrap_sticky2), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mod_toggle_counter
